// File: rtl/delay_timer_pkg.sv
// Shared types for the multi-channel delay timer.
//   mode_e  : per-channel operating mode, encoded as on the mode input bus
//   state_e : per-channel FSM state
package delay_timer_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_DLY_OP  = 2'b01,
        MODE_DLY_REL = 2'b10,
        MODE_DUAL    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        OP_WAIT,
        ACTIVE,
        REL_WAIT
    } state_e;

    // States in which the channel counter advances.
    function automatic logic is_counting(input state_e st, input mode_e md);
        return (st == OP_WAIT) || (st == REL_WAIT) ||
               ((st == ACTIVE) && (md == MODE_ONESHOT));
    endfunction

endpackage

// File: rtl/delay_timer_ch.sv
// One delay-timer channel: 2-flop trigger synchroniser, edge detect,
// mode/delay latches, saturating counter and 4-state FSM.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   trigger_in   : asynchronous trigger
//   ch_en        : synchronous enable, low forces IDLE
//   mode         : operating mode (latched on trigger rise)
//   delay_cfg    : delay / pulse width in cycles (latched on rise and fall)
//   delay_out_n  : active-low output, low exactly while in ACTIVE
//   busy         : high while the FSM is not IDLE
//   done         : 1-cycle pulse in the first cycle after a counter expiry
module delay_timer_ch
    import delay_timer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 8,
    parameter bit          RETRIGGER = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trigger_in,
    input  logic                 ch_en,
    input  logic [1:0]           mode,
    input  logic [CNT_WIDTH-1:0] delay_cfg,
    output logic                 delay_out_n,
    output logic                 busy,
    output logic                 done
);

    logic                 sync_q, trig_s, trig_p;
    logic                 rise, fall;
    mode_e                mode_q, mode_use;
    logic [CNT_WIDTH-1:0] dly_q, dly_use, cnt_q;
    state_e               state_q, state_d;
    logic                 done_d, restart, expire, cnt_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
            trig_s <= 1'b0;
            trig_p <= 1'b0;
        end else begin
            sync_q <= trigger_in;
            trig_s <= sync_q;
            trig_p <= trig_s;
        end
    end

    assign rise = trig_s & ~trig_p;
    assign fall = ~trig_s & trig_p;

    // Decisions taken on an edge use the value being latched by that edge.
    assign mode_use = rise ? mode_e'(mode) : mode_q;
    assign dly_use  = (rise | fall) ? delay_cfg : dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_ONESHOT;
            dly_q  <= '0;
        end else begin
            if (rise) mode_q <= mode_e'(mode);
            if (rise | fall) dly_q <= delay_cfg;
        end
    end

    // ">=" rather than "==" keeps expiry reachable if the latched delay
    // shrinks below the running count.
    assign expire = (dly_q == '0) || (cnt_q >= (dly_q - CNT_WIDTH'(1)));

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        restart = 1'b0;
        if (!ch_en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        unique case (mode_use)
                            MODE_ONESHOT: if (dly_use != '0) state_d = ACTIVE;
                            MODE_DLY_REL: state_d = ACTIVE;
                            default:      state_d = (dly_use == '0) ? ACTIVE : OP_WAIT;
                        endcase
                    end
                end
                OP_WAIT: begin
                    if (fall) begin
                        state_d = IDLE;
                    end else if (expire) begin
                        state_d = ACTIVE;
                        done_d  = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (mode_q == MODE_ONESHOT) begin
                        if (rise && RETRIGGER) begin
                            if (dly_use == '0) state_d = IDLE;
                            else               restart = 1'b1;
                        end else if (expire) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else if (fall) begin
                        if ((mode_q == MODE_DLY_OP) || (dly_use == '0)) state_d = IDLE;
                        else                                            state_d = REL_WAIT;
                    end
                end
                REL_WAIT: begin
                    if (rise) begin
                        state_d = ACTIVE;
                    end else if (expire) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign cnt_clr = (state_d != state_q) || restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            delay_out_n <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cnt_clr)
                cnt_q <= '0;
            else if (is_counting(state_q, mode_q) && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            // Outputs registered from next state so they coincide with it.
            delay_out_n <= (state_d != ACTIVE);
            busy        <= (state_d != IDLE);
            done        <= done_d;
        end
    end

endmodule

// File: rtl/delay_timer_mc.sv
// Multi-channel programmable delay timer: NUM_CH independent channels.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   trigger_in   : per-channel asynchronous triggers
//   ch_en        : per-channel synchronous enables
//   mode         : 2 bits per channel, channel i at [2i+1:2i]
//   delay_cfg    : CNT_WIDTH bits per channel, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   delay_out_n  : per-channel active-low outputs
//   busy         : per-channel FSM-not-idle flags
//   done         : per-channel expiry pulses
module delay_timer_mc
    import delay_timer_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_WIDTH = 8,
    parameter bit          RETRIGGER = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           trigger_in,
    input  logic [NUM_CH-1:0]           ch_en,
    input  logic [2*NUM_CH-1:0]         mode,
    input  logic [NUM_CH*CNT_WIDTH-1:0] delay_cfg,
    output logic [NUM_CH-1:0]           delay_out_n,
    output logic [NUM_CH-1:0]           busy,
    output logic [NUM_CH-1:0]           done
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        delay_timer_ch #(
            .CNT_WIDTH (CNT_WIDTH),
            .RETRIGGER (RETRIGGER)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .trigger_in  (trigger_in[i]),
            .ch_en       (ch_en[i]),
            .mode        (mode[2*i +: 2]),
            .delay_cfg   (delay_cfg[i*CNT_WIDTH +: CNT_WIDTH]),
            .delay_out_n (delay_out_n[i]),
            .busy        (busy[i]),
            .done        (done[i])
        );
    end

endmodule

// File: tb/tb_delay_timer_mc.sv
// Scoreboard bench for delay_timer_mc. dut0 uses RETRIGGER=0 and carries
// most scenarios; dut1 (RETRIGGER=1) only sees a trigger on channel 1.
// Expected output events (channel, signal, value, cycle) are queued with
// the stimulus; a monitor turns every observed output change / done pulse
// into an event and matches it against the first pending entry for that
// channel. Channels 0-3 are dut0, 4-7 are dut1.
module tb_delay_timer_mc;

    localparam int K_OUT  = 0;
    localparam int K_BUSY = 1;
    localparam int K_DONE = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  trig, trig1, ch_en;
    logic [7:0]  mode;
    logic [31:0] delay_cfg;
    logic [3:0]  out0, busy0, done0, out1, busy1, done1;

    delay_timer_mc #(.NUM_CH(4), .CNT_WIDTH(8), .RETRIGGER(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .trigger_in(trig), .ch_en(ch_en),
        .mode(mode), .delay_cfg(delay_cfg),
        .delay_out_n(out0), .busy(busy0), .done(done0)
    );

    delay_timer_mc #(.NUM_CH(4), .CNT_WIDTH(8), .RETRIGGER(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .trigger_in(trig1), .ch_en(ch_en),
        .mode(mode), .delay_cfg(delay_cfg),
        .delay_out_n(out1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int ch;
        int kind;
        int val;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    bit  mon_on   = 1'b0;

    function automatic string kname(input int k);
        case (k)
            K_OUT:   return "out_n";
            K_BUSY:  return "busy";
            default: return "done";
        endcase
    endfunction

    task automatic expect_ev(input int ch, input int kind, input int val, input int c);
        ev_t e;
        e.ch = ch; e.kind = kind; e.val = val; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic chk_ev(input int ch, input int kind, input int val);
        int idx;
        idx = -1;
        checks++;
        foreach (exp_q[i]) if (idx < 0 && exp_q[i].ch == ch) idx = i;
        if (idx < 0) begin
            failures++;
            $display("FAIL event_ch%0d: actual %s=%0d at cyc %0d, required no event",
                     ch, kname(kind), val, cyc);
        end else begin
            if (exp_q[idx].kind != kind || exp_q[idx].val != val || exp_q[idx].cyc != cyc) begin
                failures++;
                $display("FAIL event_ch%0d: actual %s=%0d at cyc %0d, required %s=%0d at cyc %0d",
                         ch, kname(kind), val, cyc,
                         kname(exp_q[idx].kind), exp_q[idx].val, exp_q[idx].cyc);
            end
            exp_q.delete(idx);
        end
    endtask

    task automatic check_vec(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual %b, required %b", name, act, req);
        end
    endtask

    // Advance to 1 time unit after the edge that makes cyc == c.
    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor
    initial begin
        logic [7:0] po, pb, co, cb, cd;
        wait (mon_on);
        po = {out1, out0};
        pb = {busy1, busy0};
        forever begin
            @(negedge clk);
            co = {out1, out0};
            cb = {busy1, busy0};
            cd = {done1, done0};
            for (int v = 0; v < 8; v++) begin
                if (co[v] != po[v]) chk_ev(v, K_OUT, int'(co[v]));
                if (cb[v] != pb[v]) chk_ev(v, K_BUSY, int'(cb[v]));
                if (cd[v])          chk_ev(v, K_DONE, 1);
            end
            po = co;
            pb = cb;
        end
    end

    // Stimulus
    initial begin
        rst_n     = 1'b1;
        trig      = '0;
        trig1     = '0;
        ch_en     = '1;
        mode      = '0;
        delay_cfg = '0;
        trig[0]          = 1'b1;           // high across reset release
        mode[1:0]        = 2'b01;  delay_cfg[7:0]   = 8'd5;
        mode[3:2]        = 2'b00;  delay_cfg[15:8]  = 8'd4;
        mode[5:4]        = 2'b01;  delay_cfg[23:16] = 8'd10;
        mode[7:6]        = 2'b11;  delay_cfg[31:24] = 8'd3;
        #1 rst_n = 1'b0;

        @(negedge clk);
        check_vec("reset_out_n_dut0", out0,  4'hF);
        check_vec("reset_busy_dut0",  busy0, 4'h0);
        check_vec("reset_done_dut0",  done0, 4'h0);
        check_vec("reset_out_n_dut1", out1,  4'hF);
        check_vec("reset_busy_dut1",  busy1, 4'h0);
        check_vec("reset_done_dut1",  done1, 4'h0);
        mon_on = 1'b1;

        // Ch0 mode 01 D=5, trigger already high at release (cyc 3).
        expect_ev(0, K_BUSY, 1, 6);
        expect_ev(0, K_OUT,  0, 11);
        expect_ev(0, K_DONE, 1, 11);
        expect_ev(0, K_OUT,  1, 18);
        expect_ev(0, K_BUSY, 0, 18);
        at(3);  rst_n = 1'b1;
        at(15); trig[0] = 1'b0;

        // Ch1 mode 00 D=4 with a second rise during the pulse.
        expect_ev(1, K_OUT,  0, 23);
        expect_ev(1, K_BUSY, 1, 23);
        expect_ev(1, K_OUT,  1, 27);
        expect_ev(1, K_BUSY, 0, 27);
        expect_ev(1, K_DONE, 1, 27);
        expect_ev(5, K_OUT,  0, 23);
        expect_ev(5, K_BUSY, 1, 23);
        expect_ev(5, K_OUT,  1, 29);
        expect_ev(5, K_BUSY, 0, 29);
        expect_ev(5, K_DONE, 1, 29);
        at(20); trig[1] = 1'b1; trig1[1] = 1'b1;
        at(21); trig[1] = 1'b0; trig1[1] = 1'b0;
        at(22); trig[1] = 1'b1; trig1[1] = 1'b1;
        at(30); trig[1] = 1'b0; trig1[1] = 1'b0;

        // Ch2 mode 01 D=10: short trigger, then long trigger.
        // Ch3 mode 11 D=3: operate, release, then rise inside REL_WAIT.
        expect_ev(2, K_BUSY, 1, 38);
        expect_ev(2, K_BUSY, 0, 44);
        expect_ev(2, K_BUSY, 1, 53);
        expect_ev(2, K_OUT,  0, 63);
        expect_ev(2, K_DONE, 1, 63);
        expect_ev(2, K_OUT,  1, 73);
        expect_ev(2, K_BUSY, 0, 73);
        expect_ev(3, K_BUSY, 1, 38);
        expect_ev(3, K_OUT,  0, 41);
        expect_ev(3, K_DONE, 1, 41);
        expect_ev(3, K_OUT,  1, 48);
        expect_ev(3, K_BUSY, 0, 51);
        expect_ev(3, K_DONE, 1, 51);
        expect_ev(3, K_BUSY, 1, 58);
        expect_ev(3, K_OUT,  0, 61);
        expect_ev(3, K_DONE, 1, 61);
        expect_ev(3, K_OUT,  1, 68);
        expect_ev(3, K_OUT,  0, 69);
        expect_ev(3, K_OUT,  1, 83);
        expect_ev(3, K_BUSY, 0, 86);
        expect_ev(3, K_DONE, 1, 86);
        at(35); trig[2] = 1'b1; trig[3] = 1'b1;
        at(41); trig[2] = 1'b0;
        at(45); trig[3] = 1'b0;
        at(50); trig[2] = 1'b1;
        at(55); trig[3] = 1'b1;
        at(65); trig[3] = 1'b0;
        at(66); trig[3] = 1'b1;
        at(70); trig[2] = 1'b0;
        at(80); trig[3] = 1'b0;

        // D=0: ch2 mode 10 follows trigger, ch1 mode 00 gives no pulse.
        expect_ev(2, K_OUT,  0, 95);
        expect_ev(2, K_BUSY, 1, 95);
        expect_ev(2, K_OUT,  1, 100);
        expect_ev(2, K_BUSY, 0, 100);
        at(90); mode[5:4] = 2'b10; delay_cfg[23:16] = 8'd0;
                mode[3:2] = 2'b00; delay_cfg[15:8]  = 8'd0;
        at(92); trig[2] = 1'b1; trig[1] = 1'b1;
        at(97); trig[2] = 1'b0; trig[1] = 1'b0;

        // All channels busy; ch_en[2] drop, re-enable with trigger high,
        // then asynchronous reset mid-wait.
        expect_ev(0, K_BUSY, 1, 109);
        expect_ev(0, K_BUSY, 0, 115);
        expect_ev(1, K_OUT,  0, 109);
        expect_ev(1, K_BUSY, 1, 109);
        expect_ev(1, K_OUT,  1, 115);
        expect_ev(1, K_BUSY, 0, 115);
        expect_ev(2, K_OUT,  0, 109);
        expect_ev(2, K_BUSY, 1, 109);
        expect_ev(2, K_OUT,  1, 113);
        expect_ev(2, K_BUSY, 0, 113);
        expect_ev(3, K_BUSY, 1, 109);
        expect_ev(3, K_BUSY, 0, 115);
        at(105); mode = 8'b11_10_00_01;
                 delay_cfg = {8'd40, 8'd5, 8'd30, 8'd20};
        at(106); trig = 4'hF;
        at(112); ch_en[2] = 1'b0;
        at(114); ch_en[2] = 1'b1;
        at(115); rst_n = 1'b0; trig = '0;
        #1;
        check_vec("midreset_out_n", out0,  4'hF);
        check_vec("midreset_busy",  busy0, 4'h0);
        at(118); rst_n = 1'b1;

        at(125);
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL event_ch%0d: actual no event, required %s=%0d at cyc %0d",
                     e.ch, kname(e.kind), e.val, e.cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
